// File: rtl/p251_mul.sv
// p251_mul: three-stage pipelined (in_1*in_2) mod 251 using 256 = 5 (mod 251) folding
module p251_mul (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] in_1,
    input  logic [7:0] in_2,
    output logic [7:0] out,
    output logic       done
);
    logic [15:0] p_q, p_d;
    logic [10:0] f1_q, f1_d;
    logic [8:0]  f2;
    logic [7:0]  out_q, out_d;
    logic        v1_q, v2_q, done_q;
    // next-state: capture product on start, fold high byte twice, one conditional subtract
    always_comb begin
        p_d   = start ? 16'(in_1) * 16'(in_2) : p_q;
        f1_d  = v1_q ? {3'b0, p_q[15:8]} * 11'd5 + {3'b0, p_q[7:0]} : f1_q;
        f2    = {6'b0, f1_q[10:8]} * 9'd5 + {1'b0, f1_q[7:0]};
        out_d = !v2_q ? out_q : f2 >= 9'd251 ? 8'(f2 - 9'd251) : f2[7:0];
    end
    // pipeline registers; reset drops every in-flight operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q    <= '0;
            f1_q   <= '0;
            out_q  <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            f1_q   <= f1_d;
            out_q  <= out_d;
            v1_q   <= start;
            v2_q   <= v1_q;
            done_q <= v2_q;
        end
    end
    assign out  = out_q;
    assign done = done_q;
endmodule

// File: tb/tb_p251_mul.sv
// tb_p251_mul: table-driven and directed checks of the mod-251 multiplier pipeline
module tb_p251_mul;
    logic       clk = 0, rst_n = 0, start = 0;
    logic [7:0] in_1 = 0, in_2 = 0, out, exp_in = 0;
    logic       done;
    int         total = 0, bad = 0, n_start = 0, n_done = 0;

    logic       m_v0 = 0, m_v1 = 0, m_done = 0;
    logic [7:0] m_o0 = 0, m_o1 = 0, m_out = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] e;
    } vec_t;
    vec_t tbl [8];

    p251_mul dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_1(in_1), .in_2(in_2), .out(out), .done(done)
    );

    always #5 clk = ~clk;

    // expected-result delay line fed with hand-computed / reference values
    always @(posedge clk) begin
        if (!rst_n) begin
            m_v0 <= 0; m_v1 <= 0; m_done <= 0; m_out <= 0;
        end else begin
            m_v0 <= start; m_o0 <= exp_in;
            m_v1 <= m_v0;  m_o1 <= m_o0;
            m_done <= m_v1;
            if (m_v1) m_out <= m_o1;
            if (start) n_start++;
        end
    end

    // compare away from the active edge
    always @(negedge clk) begin
        total++;
        if (done !== m_done) begin
            bad++;
            $display("FAIL done at %0t: got %b want %b", $time, done, m_done);
        end
        total++;
        if (out !== m_out) begin
            bad++;
            $display("FAIL out at %0t: got %0d want %0d", $time, out, m_out);
        end
        if (done === 1'b1) n_done++;
    end

    task automatic go(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [7:0] e);
        start = s; in_1 = a; in_2 = b; exp_in = e;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) go(8'h00, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        tbl[0] = '{8'd1,   8'd20,  8'd20};
        tbl[1] = '{8'd34,  8'd31,  8'd50};
        tbl[2] = '{8'd62,  8'd85,  8'd250};
        tbl[3] = '{8'd0,   8'd200, 8'd0};
        tbl[4] = '{8'd250, 8'd250, 8'd1};
        tbl[5] = '{8'd255, 8'd255, 8'd16};
        tbl[6] = '{8'd251, 8'd7,   8'd0};
        tbl[7] = '{8'd250, 8'd1,   8'd250};

        @(negedge clk);
        @(negedge clk);
        total++;
        if (out !== 8'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got out=%0d done=%b want out=0 done=0", out, done);
        end
        rst_n = 1;

        for (int i = 0; i < 8; i++) go(tbl[i].a, tbl[i].b, 1'b1, tbl[i].e);
        idle(5);

        go(8'd2, 8'd3, 1'b1, 8'd6);
        go(8'hAA, 8'h55, 1'b0, 8'd0);
        go(8'd10, 8'd26, 1'b1, 8'd9);
        idle(5);

        go(8'd5, 8'd6, 1'b1, 8'd30);
        go(8'd7, 8'd8, 1'b1, 8'd56);
        rst_n = 0;
        go(8'd9, 8'd9, 1'b1, 8'd81);
        rst_n = 1;
        idle(5);
        total++;
        if (out !== 8'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL after_reset: got out=%0d done=%b want out=0 done=0", out, done);
        end

        go(8'd100, 8'd100, 1'b1, 8'd211);
        idle(5);

        n_start = 0;
        n_done  = 0;
        for (int i = 0; i < 10000; i++) begin
            int a, b;
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            go(8'(a), 8'(b), $urandom_range(0, 3) != 0, 8'((a * b) % 251));
        end
        idle(5);
        total++;
        if (n_done != n_start) begin
            bad++;
            $display("FAIL done_count: got %0d want %0d", n_done, n_start);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
